// File: rtl/exp_result_fifo.sv
// exp_result_fifo: first-word-fall-through result buffer between the
// exponential datapath and its downstream consumer. Writes that arrive while
// the buffer is full (and no pop frees a slot) are discarded and counted in a
// saturating drop counter.
module exp_result_fifo #(
  parameter  int WIDTH = 21,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [AW:0]      count,
  output logic [7:0]       drop_cnt
);

  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);
  localparam logic [7:0]  DROP_MAX   = 8'hFF;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic             push;
  logic             pop;
  logic             drop;

  // Status flags come from the registered count only, so they never
  // combinationally depend on wr_en or out_ready.
  assign full      = (count == FULL_COUNT);
  assign out_valid = (count != '0);

  // Head entry is presented straight from storage; zero when empty so the
  // consumer never sees stale data.
  assign out_data = out_valid ? mem[rp] : '0;

  // A pop frees the head slot in the same edge, which lets a write land even
  // when the buffer is full; a write with nowhere to go is a drop.
  assign pop  = out_valid && out_ready;
  assign push = wr_en && (!full || pop);
  assign drop = wr_en && full && !pop;

  // Storage array is deliberately not reset; pointers make stale words unreachable.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wp] <= wr_data;
    end
  end

  // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) begin
        wp <= wp + 1'b1;
      end
      if (pop) begin
        rp <= rp + 1'b1;
      end
    end
  end

  // Occupancy changes only when exactly one of push/pop happens.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Lost-result counter sticks at its maximum instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != DROP_MAX)) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_exp_result_fifo.sv
// tb_exp_result_fifo: scoreboard bench for exp_result_fifo. A reference queue
// tracks every accepted write; each cycle the DUT state is checked against it.
module tb_exp_result_fifo;

  localparam int WIDTH = 21;
  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);

  logic             clk;
  logic             rst;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             full;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [AW:0]      count;
  logic [7:0]       drop_cnt;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] model_q[$];
  logic [WIDTH-1:0] popped_dut[$];
  int               model_drop = 0;
  bit               armed = 0;
  bit               m_pop;
  bit               m_full;

  exp_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count),
    .drop_cnt  (drop_cnt)
  );

  // Free-running clock, 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, then wait until just after the active edge.
  task automatic apply_stimulus(input logic we, input logic [WIDTH-1:0] d,
                                input logic rdy, input logic rs);
    wr_en     = we;
    wr_data   = d;
    out_ready = rdy;
    rst       = rs;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare DUT state to the reference on the falling edge, then
  // advance the reference by what the coming rising edge should do.
  always @(negedge clk) begin
    if (armed) begin
      check_output("out_valid", out_valid, model_q.size() > 0);
      check_output("full", full, model_q.size() == DEPTH);
      check_output("count", count, model_q.size());
      check_output("drop_cnt", drop_cnt, model_drop);
      check_output("out_data", out_data, (model_q.size() > 0) ? model_q[0] : '0);
      if (!rst && out_valid && out_ready) begin
        popped_dut.push_back(out_data);
      end
    end
    if (rst) begin
      model_q.delete();
      model_drop = 0;
      armed      = 1'b1;
    end else if (armed) begin
      m_pop  = (model_q.size() > 0) && out_ready;
      m_full = (model_q.size() == DEPTH);
      if (m_pop) begin
        void'(model_q.pop_front());
      end
      if (wr_en) begin
        if (!m_full || m_pop) begin
          model_q.push_back(wr_data);
        end else if (model_drop != 255) begin
          model_drop++;
        end
      end
    end
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios; the scoreboard checks every cycle in the background.
  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; out_ready = 1'b0;
    apply_stimulus(1'b0, '0, 1'b0, 1'b1);
    apply_stimulus(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, '0, 1'b0, 1'b0);
    check_output("idle_valid", out_valid, 0);
    check_output("idle_full", full, 0);
    check_output("idle_count", count, 0);
    check_output("idle_drop", drop_cnt, 0);
    check_output("idle_data", out_data, 0);

    $display("[TB] two writes then drain");
    popped_dut.delete();
    apply_stimulus(1'b1, 21'h1ABCDE, 1'b0, 1'b0);
    check_output("w1_data", out_data, 21'h1ABCDE);
    apply_stimulus(1'b1, 21'h00001, 1'b0, 1'b0);
    check_output("w2_count", count, 2);
    apply_stimulus(1'b0, '0, 1'b1, 1'b0);
    check_output("d1_count", count, 1);
    check_output("d1_data", out_data, 21'h00001);
    apply_stimulus(1'b0, '0, 1'b1, 1'b0);
    check_output("d2_count", count, 0);
    check_output("d2_valid", out_valid, 0);
    check_output("d_n", popped_dut.size(), 2);
    if (popped_dut.size() == 2) begin
      check_output("d_0", popped_dut[0], 21'h1ABCDE);
      check_output("d_1", popped_dut[1], 21'h00001);
    end

    $display("[TB] overfill, write-at-full with pop, drain");
    popped_dut.delete();
    for (int i = 1; i <= 5; i++) apply_stimulus(1'b1, WIDTH'(i), 1'b0, 1'b0);
    check_output("of_full", full, 1);
    check_output("of_drop", drop_cnt, 1);
    apply_stimulus(1'b1, 21'd9, 1'b1, 1'b0);
    check_output("fp_count", count, 4);
    check_output("fp_drop", drop_cnt, 1);
    for (int i = 0; i < 4; i++) apply_stimulus(1'b0, '0, 1'b1, 1'b0);
    check_output("fp_empty", out_valid, 0);
    check_output("fp_n", popped_dut.size(), 5);
    if (popped_dut.size() == 5) begin
      check_output("fp_0", popped_dut[0], 1);
      check_output("fp_1", popped_dut[1], 2);
      check_output("fp_2", popped_dut[2], 3);
      check_output("fp_3", popped_dut[3], 4);
      check_output("fp_4", popped_dut[4], 9);
    end

    $display("[TB] streaming with ready held high");
    apply_stimulus(1'b0, '0, 1'b0, 1'b1);
    popped_dut.delete();
    for (int i = 0; i < 10; i++) apply_stimulus(1'b1, WIDTH'(100 + i), 1'b1, 1'b0);
    apply_stimulus(1'b0, '0, 1'b1, 1'b0);
    check_output("st_drop", drop_cnt, 0);
    check_output("st_n", popped_dut.size(), 10);
    for (int i = 0; i < 10 && i < popped_dut.size(); i++)
      check_output("st_word", popped_dut[i], 100 + i);

    $display("[TB] reset mid-stream, then saturate drops");
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, WIDTH'(50 + i), 1'b0, 1'b0);
    check_output("rs_pre", count, 3);
    apply_stimulus(1'b1, 21'h777, 1'b1, 1'b1);
    check_output("rs_count", count, 0);
    check_output("rs_valid", out_valid, 0);
    for (int i = 0; i < 260; i++) apply_stimulus(1'b1, WIDTH'(i), 1'b0, 1'b0);
    check_output("sat_drop", drop_cnt, 255);
    check_output("sat_full", full, 1);
    apply_stimulus(1'b0, '0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
